french_motion_ctrl: RTL and testbench

//   Sequences the 32x32 "french" sprite drawer: owns ObjectStartX/ObjectStartY, moves the sprite

---
 rtl/french_motion_ctrl.sv | 149 ++++++++++++++
 tb/tb_french_motion_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/french_motion_ctrl.sv
// Lane motion sequencer for the 32x32 "french" sprite: owns its top-left position,
// steps it once per video frame with edge bounce, and hides/respawns it after a hit.
module french_motion_ctrl #(
  parameter int unsigned INIT_X         = 64,
  parameter int unsigned INIT_Y         = 240,
  parameter int unsigned X_MIN          = 0,
  parameter int unsigned X_MAX          = 639,
  parameter int unsigned OBJ_W          = 32,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic [3:0]  speed,
  input  logic        hit,
  output logic [10:0] ObjectStartX,
  output logic [10:0] ObjectStartY,
  output logic        visible,
  output logic        dir_left,
  output logic [1:0]  state_o
);

  localparam int unsigned XW = 11;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 8;

  localparam logic [AW-1:0] X_MIN_A   = AW'(X_MIN);
  localparam logic [AW-1:0] X_MAX_A   = AW'(X_MAX);
  localparam logic [AW-1:0] W_M1_A    = AW'(OBJ_W - 1);
  localparam logic [AW-1:0] X_RIGHT_A = AW'(X_MAX - OBJ_W + 1);
  localparam logic [XW-1:0] INIT_X_V  = XW'(INIT_X);
  localparam logic [XW-1:0] INIT_Y_V  = XW'(INIT_Y);
  localparam logic [CW-1:0] RESPAWN_V = CW'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MOVE = 2'b01,
    S_HIT  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic            dir_q, dir_d;
  logic            vis_q, vis_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]   x_a, s_a;
  logic [XW-1:0]   step_x;
  logic            step_dir;

  // One frame step with bounce; 12-bit arithmetic so the lane limits never wrap
  always_comb begin
    x_a      = {1'b0, x_q};
    s_a      = AW'(speed);
    step_x   = x_q;
    step_dir = dir_q;
    if (speed != 4'd0) begin
      if (!dir_q) begin
        if (x_a + s_a + W_M1_A >= X_MAX_A) begin
          step_x   = XW'(X_RIGHT_A);
          step_dir = 1'b1;
        end else begin
          step_x = XW'(x_a + s_a);
        end
      end else begin
        if (x_a < X_MIN_A + s_a) begin
          step_x   = XW'(X_MIN_A);
          step_dir = 1'b0;
        end else begin
          step_x = XW'(x_a - s_a);
        end
      end
    end
  end

  // Next state; enable=0 outranks hit, which outranks the frame step
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    dir_d   = dir_q;
    vis_d   = vis_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = S_IDLE;
      vis_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_MOVE;
          vis_d   = 1'b1;
        end
        S_MOVE: begin
          if (hit) begin
            state_d = S_HIT;
            vis_d   = 1'b0;
            cnt_d   = RESPAWN_V;
          end else if (startOfFrame) begin
            x_d   = step_x;
            dir_d = step_dir;
          end
        end
        S_HIT: begin
          vis_d = 1'b0;
          if (startOfFrame) begin
            if (cnt_q <= CW'(1)) begin
              cnt_d   = '0;
              x_d     = INIT_X_V;
              dir_d   = 1'b0;
              vis_d   = 1'b1;
              state_d = S_MOVE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          vis_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      x_q     <= INIT_X_V;
      dir_q   <= 1'b0;
      vis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
      vis_q   <= vis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ObjectStartX = x_q;
  assign ObjectStartY = INIT_Y_V;
  assign visible      = vis_q;
  assign dir_left     = dir_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_french_motion_ctrl.sv
// Bench for french_motion_ctrl: directed lane/bounce/hit scenarios plus random traffic,
// checked every cycle against a plain-integer model of the motion rules.
module tb_french_motion_ctrl;

  localparam int RESP = 3;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic        hit = 1'b0;
  logic [10:0] ObjectStartX;
  logic [10:0] ObjectStartY;
  logic        visible;
  logic        dir_left;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  // model: lane position in plain integers
  int m_x = 64, m_dir = 0, m_vis = 0, m_st = 0, m_cnt = 0;

  french_motion_ctrl #(.RESPAWN_FRAMES(RESP)) dut (
    .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame), .enable(enable),
    .speed(speed), .hit(hit), .ObjectStartX(ObjectStartX), .ObjectStartY(ObjectStartY),
    .visible(visible), .dir_left(dir_left), .state_o(state_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_x = 64; m_dir = 0; m_vis = 0; m_st = 0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    int s;
    s = int'(speed);
    if (!enable) begin
      m_st = 0; m_vis = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_vis = 1;
    end else if (m_st == 1) begin
      if (hit) begin
        m_st = 2; m_vis = 0; m_cnt = RESP;
      end else if (startOfFrame && s != 0) begin
        if (m_dir == 0) begin
          if (m_x + s + 31 >= 639) begin m_x = 608; m_dir = 1; end
          else m_x = m_x + s;
        end else begin
          if (m_x < s) begin m_x = 0; m_dir = 0; end
          else m_x = m_x - s;
        end
      end
    end else if (startOfFrame) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_x = 64; m_dir = 0; m_vis = 1; m_st = 1;
      end
    end
  endfunction

  // Model update on every edge the DUT reacts to, compare shortly after
  initial forever begin
    @(posedge CLK or negedge RESETn);
    if (!RESETn) model_reset();
    else model_step();
    #1;
    n_cmp++;
    if (int'(ObjectStartX) != m_x || int'(ObjectStartY) != 240 || int'(visible) != m_vis ||
        int'(dir_left) != m_dir || int'(state_o) != m_st) begin
      n_bad++;
      $display("FAIL cycle @%0t: got x=%0d y=%0d vis=%0d dir=%0d st=%0d expected x=%0d y=240 vis=%0d dir=%0d st=%0d",
               $time, ObjectStartX, ObjectStartY, visible, dir_left, state_o,
               m_x, m_vis, m_dir, m_st);
    end
  end

  task automatic frame(input int s);
    startOfFrame = 1'b1;
    speed = 4'(s);
    @(negedge CLK);
    startOfFrame = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge CLK);
    hit = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    check("rst_x", int'(ObjectStartX), 64);
    check("rst_y", int'(ObjectStartY), 240);
    check("rst_vis", int'(visible), 0);
    check("rst_dir", int'(dir_left), 0);
    check("rst_state", int'(state_o), 0);

    enable = 1'b1;
    @(negedge CLK);
    check("en_vis", int'(visible), 1);
    check("en_state", int'(state_o), 1);

    for (int i = 0; i < 3; i++) begin
      frame(4);
      check("step4_x", int'(ObjectStartX), 68 + 4 * i);
    end
    check("model_x76", m_x, 76);

    repeat (34) frame(15);
    frame(14);
    check("pre_right_x", int'(ObjectStartX), 600);
    frame(10);
    check("right_clamp_x", int'(ObjectStartX), 608);
    check("right_clamp_dir", int'(dir_left), 1);
    frame(10);
    check("after_right_x", int'(ObjectStartX), 598);

    repeat (39) frame(15);
    frame(10);
    check("pre_left_x", int'(ObjectStartX), 3);
    frame(5);
    check("left_clamp_x", int'(ObjectStartX), 0);
    check("left_clamp_dir", int'(dir_left), 0);
    frame(5);
    check("after_left_x", int'(ObjectStartX), 5);

    repeat (6) frame(15);
    frame(5);
    check("pre_hit_x", int'(ObjectStartX), 100);
    hit = 1'b1; startOfFrame = 1'b1; speed = 4'd7;
    @(negedge CLK);
    hit = 1'b0; startOfFrame = 1'b0;
    check("hitsof_state", int'(state_o), 2);
    check("hitsof_x", int'(ObjectStartX), 100);
    check("hitsof_vis", int'(visible), 0);
    frame(7);
    pulse_hit();
    frame(7);
    check("hit_hold_state", int'(state_o), 2);
    frame(7);
    check("respawn_x", int'(ObjectStartX), 64);
    check("respawn_vis", int'(visible), 1);
    check("respawn_state", int'(state_o), 1);
    check("model_respawn", m_st, 1);

    frame(10);
    pulse_hit();
    frame(1);
    enable = 1'b0;
    @(negedge CLK);
    check("dis_state", int'(state_o), 0);
    check("dis_vis", int'(visible), 0);
    enable = 1'b1;
    @(negedge CLK);
    check("reen_state", int'(state_o), 1);
    check("reen_x", int'(ObjectStartX), 74);
    frame(0);
    frame(0);
    check("speed0_x", int'(ObjectStartX), 74);
    check("speed0_dir", int'(dir_left), 0);

    frame(9);
    RESETn = 1'b0;
    #2;
    check("async_rst_x", int'(ObjectStartX), 64);
    check("async_rst_state", int'(state_o), 0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom % 40) != 0;
      startOfFrame = ($urandom % 4) == 0;
      hit          = ($urandom % 30) == 0;
      speed        = 4'($urandom % 16);
      RESETn       = ($urandom % 700) != 0;
      @(negedge CLK);
    end
    RESETn = 1'b1;
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
